// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports with same-cycle write bypass,
// x0 hardwired to zero, plus a registered commit counter and last-written index.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic [31:0] wcount,
    output logic [4:0]  last_waddr
);

    localparam int REG_NUM = 32;

    logic [31:0] r_regs [REG_NUM];
    logic [31:0] r_wcount;
    logic [4:0]  r_last_waddr;
    logic        w_commit;

    // Writes to x0 are dropped entirely, so they never touch the counters either.
    assign w_commit = we && (waddr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_wcount     <= 32'd0;
            r_last_waddr <= 5'd0;
        end else if (w_commit) begin
            r_regs[waddr] <= wdata;
            r_wcount      <= r_wcount + 32'd1;
            r_last_waddr  <= waddr;
        end
    end

    always_comb begin
        rdata1 = 32'd0;
        if (rst || !re1 || (raddr1 == 5'd0)) begin
            rdata1 = 32'd0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = r_regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = 32'd0;
        if (rst || !re2 || (raddr2 == 5'd0)) begin
            rdata2 = 32'd0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = r_regs[raddr2];
        end
    end

    assign wcount     = r_wcount;
    assign last_waddr = r_last_waddr;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, bypass, x0, counter wrap and mid-run reset.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] wcount;
    logic [4:0]  last_waddr;

    int n_checks;
    int n_errors;

    regfile dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .wcount     (wcount),
        .last_waddr (last_waddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b0;
        we     = 1'b0;
        waddr  = 5'd0;
        wdata  = 32'd0;
        re1    = 1'b0;
        raddr1 = 5'd0;
        re2    = 1'b0;
        raddr2 = 5'd0;

        // Asynchronous reset while clk is low, before any rising edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_wcount", wcount, 32'd0);
        chk("rst_last", {27'd0, last_waddr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        re1 = 1'b1;
        re2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = i[4:0];
            raddr2 = 5'd31 - i[4:0];
            #1;
            chk("rst_rd1", rdata1, 32'd0);
            chk("rst_rd2", rdata2, 32'd0);
        end

        // Write x5, read back the cycle after.
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        re1 = 1'b0; re2 = 1'b0;
        @(negedge clk);
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        chk("wr_rd1", rdata1, 32'hDEADBEEF);
        chk("wr_wcount", wcount, 32'd1);
        chk("wr_last", {27'd0, last_waddr}, 32'd5);
        re1 = 1'b0;
        #1;
        chk("re1_off", rdata1, 32'd0);

        // Same-cycle bypass on both ports, then disabled port 2.
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        re1 = 1'b1; raddr1 = 5'd7;
        re2 = 1'b1; raddr2 = 5'd7;
        #1;
        chk("byp_rd1", rdata1, 32'h12345678);
        chk("byp_rd2", rdata2, 32'h12345678);
        chk("byp_wcount_pre", wcount, 32'd1);
        re2 = 1'b0;
        #1;
        chk("byp_re2_off", rdata2, 32'd0);
        @(negedge clk);
        we = 1'b0; re2 = 1'b1;
        #1;
        chk("stored_rd1", rdata1, 32'h12345678);
        chk("stored_rd2", rdata2, 32'h12345678);
        chk("byp_wcount", wcount, 32'd2);
        chk("byp_last", {27'd0, last_waddr}, 32'd7);
        raddr2 = 5'd5;
        #1;
        chk("indep_rd2", rdata2, 32'hDEADBEEF);

        // Writes to x0 are discarded and never bypassed.
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        raddr1 = 5'd0;
        #1;
        chk("x0_rd_during", rdata1, 32'd0);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("x0_rd_after", rdata1, 32'd0);
        chk("x0_wcount", wcount, 32'd2);
        chk("x0_last", {27'd0, last_waddr}, 32'd7);

        // Counter wrap from a forced all-ones value.
        @(negedge clk);
        force dut.r_wcount = 32'hFFFFFFFF;
        #1;
        release dut.r_wcount;
        #1;
        chk("wrap_pre", wcount, 32'hFFFFFFFF);
        we = 1'b1; waddr = 5'd3; wdata = 32'h00000033;
        @(negedge clk);
        we = 1'b0; raddr1 = 5'd3;
        #1;
        chk("wrap_wcount", wcount, 32'd0);
        chk("wrap_last", {27'd0, last_waddr}, 32'd3);
        chk("wrap_rd", rdata1, 32'h00000033);

        // Fill x1..x31, then reset asynchronously between edges.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1; waddr = i[4:0]; wdata = 32'h01010101 * i;
        end
        @(negedge clk);
        we = 1'b0;
        raddr1 = 5'd31; raddr2 = 5'd9;
        #1;
        chk("fill_rd31", rdata1, 32'h1F1F1F1F);
        chk("fill_rd9", rdata2, 32'h09090909);
        chk("fill_wcount", wcount, 32'd31);
        chk("fill_last", {27'd0, last_waddr}, 32'd31);
        #1 rst = 1'b1;
        #1;
        chk("mrst_rd1", rdata1, 32'd0);
        chk("mrst_rd2", rdata2, 32'd0);
        chk("mrst_wcount", wcount, 32'd0);
        chk("mrst_last", {27'd0, last_waddr}, 32'd0);

        // A write held across an edge while reset is high must be ignored.
        we = 1'b1; waddr = 5'd9; wdata = 32'h00000077;
        @(negedge clk);
        chk("rst_wr_wcount", wcount, 32'd0);
        rst = 1'b0;
        we = 1'b0;
        #1;
        chk("rst_wr_rd9", rdata2, 32'd0);
        chk("rst_wr_rd31", rdata1, 32'd0);

        // First write after reset release.
        we = 1'b1; waddr = 5'd9; wdata = 32'h000000A5;
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("post_rd9", rdata2, 32'h000000A5);
        chk("post_wcount", wcount, 32'd1);
        chk("post_last", {27'd0, last_waddr}, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
